// File: rtl/sa_sched_pkg.sv
// Shared types and width helpers for the systolic job scheduler blocks.
package sa_sched_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, DRAIN, CLEAR} state_t;

  // Counters that must hold the value n itself (0..n).
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Indices 0..n-1; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sa_rr_arbiter.sv
// Combinational round-robin pick: first request at or after the pointer, wrapping.
module sa_rr_arbiter
  import sa_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IW      = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IW-1:0]      o_gnt_idx
);

  always_comb begin : pick
    logic          w_found;
    logic [IW-1:0] w_pos;
    int            p;
    o_gnt     = '0;
    o_gnt_idx = '0;
    w_found   = 1'b0;
    w_pos     = '0;
    p         = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      p = int'(i_ptr) + off;
      if (p >= NUM_REQ) p = p - NUM_REQ;
      w_pos = IW'(p);
      if (!w_found && i_req[w_pos]) begin
        w_found      = 1'b1;
        o_gnt[w_pos] = 1'b1;
        o_gnt_idx    = w_pos;
      end
    end
  end

endmodule

// File: rtl/systolic_job_arbiter.sv
// Time-shares one systolic array between requesters: buffer a job, issue it
// back-to-back, forward the tagged result rows, then reset the array.
module systolic_job_arbiter
  import sa_sched_pkg::*;
#(
  parameter int DATAWIDTH      = 16,
  parameter int N_SIZE         = 5,
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CLEAR_CYCLES   = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ*N_SIZE*DATAWIDTH-1:0] req_a_col,
  input  logic [NUM_REQ*N_SIZE*DATAWIDTH-1:0] req_b_row,
  output logic                               sa_rst_n,
  output logic                               sa_valid_in,
  output logic [N_SIZE*DATAWIDTH-1:0]        sa_matrix_a,
  output logic [N_SIZE*DATAWIDTH-1:0]        sa_matrix_b,
  input  logic                               sa_valid_out,
  input  logic [N_SIZE*2*DATAWIDTH-1:0]      sa_matrix_c,
  output logic                               res_valid,
  output logic [N_SIZE*2*DATAWIDTH-1:0]      res_row,
  output logic [idx_width(NUM_REQ)-1:0]      res_id,
  output logic [idx_width(N_SIZE)-1:0]       res_row_idx,
  output logic                               busy,
  output logic                               err_timeout
);

  localparam int IW  = idx_width(NUM_REQ);
  localparam int RW  = idx_width(N_SIZE);
  localparam int CW  = cnt_width(N_SIZE);
  localparam int TW  = cnt_width(TIMEOUT_CYCLES);
  localparam int KW  = cnt_width(CLEAR_CYCLES);
  localparam int VW  = N_SIZE * DATAWIDTH;
  localparam int CRW = N_SIZE * 2 * DATAWIDTH;

  state_t             r_state, w_state_next;
  logic [IW-1:0]      r_gnt, w_gnt_next, r_rr, w_rr_next, w_arb_idx, r_res_id, w_res_id_next;
  logic [NUM_REQ-1:0] w_arb_gnt, r_req_ready, w_req_ready_next;
  logic [CW-1:0]      r_beat_cnt, w_beat_cnt_next, r_row_cnt, w_row_cnt_next;
  logic [TW-1:0]      r_tmo_cnt, w_tmo_cnt_next;
  logic [KW-1:0]      r_clr_cnt, w_clr_cnt_next;
  logic               r_sa_rst_n, w_sa_rst_n_next, r_sa_valid, w_sa_valid_next;
  logic [VW-1:0]      r_sa_a, w_sa_a_next, r_sa_b, w_sa_b_next;
  logic               r_res_valid, w_res_valid_next, r_busy, r_err, w_err_next;
  logic [CRW-1:0]     r_res_row, w_res_row_next;
  logic [RW-1:0]      r_res_idx, w_res_idx_next;
  logic [VW-1:0]      r_buf_a [N_SIZE];
  logic [VW-1:0]      r_buf_b [N_SIZE];
  logic               w_accept, w_buf_we;
  logic [VW-1:0]      w_sel_a, w_sel_b;

  sa_rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
    .i_req     (req_valid),
    .i_ptr     (r_rr),
    .o_gnt     (w_arb_gnt),
    .o_gnt_idx (w_arb_idx)
  );

  // r_req_ready only ever has the owner's bit set, so this is the owner's handshake.
  assign w_accept = |(req_valid & r_req_ready);
  assign w_sel_a  = req_a_col[r_gnt*VW +: VW];
  assign w_sel_b  = req_b_row[r_gnt*VW +: VW];

  always_comb begin
    w_state_next     = r_state;
    w_gnt_next       = r_gnt;
    w_rr_next        = r_rr;
    w_req_ready_next = r_req_ready;
    w_beat_cnt_next  = r_beat_cnt;
    w_row_cnt_next   = r_row_cnt;
    w_tmo_cnt_next   = r_tmo_cnt;
    w_clr_cnt_next   = r_clr_cnt;
    w_sa_rst_n_next  = 1'b1;
    w_sa_valid_next  = 1'b0;
    w_sa_a_next      = '0;
    w_sa_b_next      = '0;
    w_res_valid_next = 1'b0;
    w_res_row_next   = r_res_row;
    w_res_id_next    = r_res_id;
    w_res_idx_next   = r_res_idx;
    w_err_next       = 1'b0;
    w_buf_we         = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (|req_valid) begin
          w_gnt_next       = w_arb_idx;
          w_req_ready_next = w_arb_gnt;
          w_beat_cnt_next  = '0;
          w_state_next     = LOAD;
        end
      end
      LOAD: begin
        if (w_accept) begin
          w_buf_we        = 1'b1;
          w_beat_cnt_next = r_beat_cnt + CW'(1);
          if (r_beat_cnt + CW'(1) == CW'(N_SIZE)) begin
            w_req_ready_next = '0;
            w_beat_cnt_next  = '0;
            w_state_next     = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (r_beat_cnt < CW'(N_SIZE)) begin
          w_sa_valid_next = 1'b1;
          w_sa_a_next     = r_buf_a[r_beat_cnt[RW-1:0]];
          w_sa_b_next     = r_buf_b[r_beat_cnt[RW-1:0]];
          w_beat_cnt_next = r_beat_cnt + CW'(1);
        end else begin
          w_tmo_cnt_next = '0;
          w_row_cnt_next = '0;
          w_state_next   = WAIT;
        end
      end
      WAIT, DRAIN: begin
        if (sa_valid_out) begin
          w_res_valid_next = 1'b1;
          w_res_row_next   = sa_matrix_c;
          w_res_id_next    = r_gnt;
          w_res_idx_next   = r_row_cnt[RW-1:0];
          w_row_cnt_next   = r_row_cnt + CW'(1);
          if (r_row_cnt == CW'(N_SIZE - 1)) begin
            w_clr_cnt_next  = '0;
            w_sa_rst_n_next = 1'b0;
            w_state_next    = CLEAR;
          end else begin
            w_state_next = DRAIN;
          end
        end else if (r_state == WAIT) begin
          w_tmo_cnt_next = r_tmo_cnt + TW'(1);
          if (r_tmo_cnt + TW'(1) == TW'(TIMEOUT_CYCLES)) begin
            w_err_next      = 1'b1;
            w_clr_cnt_next  = '0;
            w_sa_rst_n_next = 1'b0;
            w_state_next    = CLEAR;
          end
        end
      end
      CLEAR: begin
        if (r_clr_cnt + KW'(1) == KW'(CLEAR_CYCLES)) begin
          w_rr_next    = (r_gnt == IW'(NUM_REQ - 1)) ? '0 : r_gnt + IW'(1);
          w_state_next = IDLE;
        end else begin
          w_clr_cnt_next  = r_clr_cnt + KW'(1);
          w_sa_rst_n_next = 1'b0;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_gnt       <= '0;
      r_rr        <= '0;
      r_req_ready <= '0;
      r_beat_cnt  <= '0;
      r_row_cnt   <= '0;
      r_tmo_cnt   <= '0;
      r_clr_cnt   <= '0;
      r_sa_rst_n  <= 1'b0;
      r_sa_valid  <= 1'b0;
      r_sa_a      <= '0;
      r_sa_b      <= '0;
      r_res_valid <= 1'b0;
      r_res_row   <= '0;
      r_res_id    <= '0;
      r_res_idx   <= '0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_gnt       <= w_gnt_next;
      r_rr        <= w_rr_next;
      r_req_ready <= w_req_ready_next;
      r_beat_cnt  <= w_beat_cnt_next;
      r_row_cnt   <= w_row_cnt_next;
      r_tmo_cnt   <= w_tmo_cnt_next;
      r_clr_cnt   <= w_clr_cnt_next;
      r_sa_rst_n  <= w_sa_rst_n_next;
      r_sa_valid  <= w_sa_valid_next;
      r_sa_a      <= w_sa_a_next;
      r_sa_b      <= w_sa_b_next;
      r_res_valid <= w_res_valid_next;
      r_res_row   <= w_res_row_next;
      r_res_id    <= w_res_id_next;
      r_res_idx   <= w_res_idx_next;
      r_busy      <= (w_state_next != IDLE);
      r_err       <= w_err_next;
    end
  end

  // Beat storage needs no reset: it is always fully rewritten before ISSUE reads it.
  always_ff @(posedge clk) begin
    if (w_buf_we) begin
      r_buf_a[r_beat_cnt[RW-1:0]] <= w_sel_a;
      r_buf_b[r_beat_cnt[RW-1:0]] <= w_sel_b;
    end
  end

  assign req_ready   = r_req_ready;
  assign sa_rst_n    = r_sa_rst_n;
  assign sa_valid_in = r_sa_valid;
  assign sa_matrix_a = r_sa_a;
  assign sa_matrix_b = r_sa_b;
  assign res_valid   = r_res_valid;
  assign res_row     = r_res_row;
  assign res_id      = r_res_id;
  assign res_row_idx = r_res_idx;
  assign busy        = r_busy;
  assign err_timeout = r_err;

endmodule

// File: tb/tb_systolic_job_arbiter.sv
// Scoreboard bench: behavioural 2x2 array stub, directed jobs, monitor checks results.
module tb_systolic_job_arbiter;

  localparam int DW = 16;
  localparam int N  = 2;
  localparam int NR = 2;
  localparam int TO = 10;
  localparam int CL = 2;
  localparam int LAT = 3;

  logic              clk, rst_n;
  logic              v0, v1;
  logic [31:0]       a0c, a1c, b0c, b1c;
  logic [NR-1:0]     req_valid, req_ready;
  logic [63:0]       req_a_col, req_b_row;
  logic              sa_rst_n, sa_valid_in, sa_valid_out;
  logic [31:0]       sa_matrix_a, sa_matrix_b;
  logic [63:0]       sa_matrix_c, res_row;
  logic              res_valid, busy, err_timeout;
  logic [0:0]        res_id, res_row_idx;

  assign req_valid = {v1, v0};
  assign req_a_col = {a1c, a0c};
  assign req_b_row = {b1c, b0c};

  systolic_job_arbiter #(.DATAWIDTH(DW), .N_SIZE(N), .NUM_REQ(NR),
                         .TIMEOUT_CYCLES(TO), .CLEAR_CYCLES(CL)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a_col(req_a_col), .req_b_row(req_b_row), .sa_rst_n(sa_rst_n),
    .sa_valid_in(sa_valid_in), .sa_matrix_a(sa_matrix_a), .sa_matrix_b(sa_matrix_b),
    .sa_valid_out(sa_valid_out), .sa_matrix_c(sa_matrix_c), .res_valid(res_valid),
    .res_row(res_row), .res_id(res_id), .res_row_idx(res_row_idx), .busy(busy),
    .err_timeout(err_timeout)
  );

  typedef struct packed {
    logic [63:0] row;
    logic        id;
    logic        idx;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   err_cnt = 0;
  bit   stub_mute = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] v2(input int e0, input int e1);
    return {16'(e1), 16'(e0)};
  endfunction

  task automatic expect_rows(input int id, input int c00, c01, c10, c11);
    exp_t e;
    e.id = 1'(id); e.idx = 1'b0; e.row = {32'(c01), 32'(c00)}; sb.push_back(e);
    e.idx = 1'b1; e.row = {32'(c11), 32'(c10)}; sb.push_back(e);
  endtask

  task automatic drive(input int r, input bit v, input logic [31:0] a, input logic [31:0] b);
    if (r == 0) begin v0 = v; a0c = a; b0c = b; end
    else        begin v1 = v; a1c = a; b1c = b; end
  endtask

  task automatic do_job(input int r, input logic [31:0] ca0, ca1, rb0, rb1, input int gap);
    logic [31:0] av[2];
    logic [31:0] bv[2];
    av[0] = ca0; av[1] = ca1; bv[0] = rb0; bv[1] = rb1;
    for (int k = 0; k < N; k++) begin
      int w;
      @(negedge clk);
      drive(r, 1'b1, av[k], bv[k]);
      w = 0;
      while (!req_ready[r] && w < 300) begin
        @(negedge clk);
        w++;
      end
      check("ready_wait_bound", 64'(w >= 300), 64'd0);
      @(posedge clk);
      #1 drive(r, 1'b0, av[k], bv[k]);
      $display("[TB] req%0d beat %0d accepted a=%h b=%h", r, k, av[k], bv[k]);
      if (k < N - 1) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          check("load_stall_no_issue", 64'(sa_valid_in), 64'd0);
        end
      end
    end
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    @(negedge clk);
    while (busy && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("wait_idle_bound", 64'(w >= 300), 64'd0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_sa_valid_in"}, 64'(sa_valid_in), 64'd0);
    check({tag, "_sa_a"}, 64'(sa_matrix_a), 64'd0);
    check({tag, "_sa_b"}, 64'(sa_matrix_b), 64'd0);
    check({tag, "_sa_rst_n"}, 64'(sa_rst_n), 64'd0);
    check({tag, "_res_valid"}, 64'(res_valid), 64'd0);
    check({tag, "_res_row"}, res_row, 64'd0);
    check({tag, "_res_id"}, 64'(res_id), 64'd0);
    check({tag, "_res_idx"}, 64'(res_row_idx), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_err"}, 64'(err_timeout), 64'd0);
  endtask

  // Behavioural array: accumulates outer products, emits rows LAT cycles after the last beat.
  initial begin : stub
    logic [31:0] acc[2][2];
    int st_in, st_cd, st_out;
    bit st_emit;
    sa_valid_out = 0; sa_matrix_c = '0;
    st_in = 0; st_cd = 0; st_out = 0; st_emit = 0;
    for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) acc[i][j] = '0;
    forever begin
      @(negedge clk);
      if (!sa_rst_n) begin
        for (int i = 0; i < 2; i++) for (int j = 0; j < 2; j++) acc[i][j] = '0;
        st_in = 0; st_cd = 0; st_out = 0; st_emit = 0;
        sa_valid_out = 0; sa_matrix_c = '0;
      end else begin
        sa_valid_out = 0;
        if (st_emit) begin
          sa_valid_out = 1;
          sa_matrix_c = {acc[st_out][1], acc[st_out][0]};
          st_out++;
          if (st_out == N) st_emit = 0;
        end
        if (sa_valid_in) begin
          for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
              acc[i][j] = acc[i][j] + 32'(sa_matrix_a[i*DW +: DW]) * 32'(sa_matrix_b[j*DW +: DW]);
          st_in++;
          if (st_in == N) st_cd = LAT;
        end else if (st_cd > 0) begin
          st_cd--;
          if (st_cd == 0 && !stub_mute) begin st_emit = 1; st_out = 0; end
        end
      end
    end
  end

  // Monitor: scoreboard pops, issue burst length, clear length, timeout latency.
  initial begin : monitor
    exp_t e;
    bit prev_vin, prev_err, tmo_arm, discard;
    int run, low_run, tmo_cnt;
    prev_vin = 0; prev_err = 0; tmo_arm = 0; discard = 0;
    run = 0; low_run = 0; tmo_cnt = 0;
    forever begin
      @(negedge clk);
      if (res_valid) begin
        $display("[TB] res id=%0d idx=%0d row=%h", res_id, res_row_idx, res_row);
        if (sb.size() == 0) begin
          check("unexpected_res_valid", 64'(res_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          check("res_row", res_row, e.row);
          check("res_id", 64'(res_id), 64'(e.id));
          check("res_row_idx", 64'(res_row_idx), 64'(e.idx));
        end
      end
      if (!rst_n) run = 0;
      else if (sa_valid_in) run++;
      else if (run > 0) begin
        check("issue_burst_len", 64'(run), 64'(N));
        run = 0;
      end
      if (!rst_n) discard = 1;
      if (!sa_rst_n) low_run++;
      else if (low_run > 0) begin
        if (!discard) check("clear_len", 64'(low_run), 64'(CL));
        low_run = 0;
        discard = 0;
      end
      if (err_timeout) err_cnt++;
      if (err_timeout && prev_err) check("err_pulse_width", 64'd2, 64'd1);
      if (prev_vin && !sa_valid_in && stub_mute) begin
        tmo_arm = 1; tmo_cnt = 0;
      end else if (tmo_arm) begin
        tmo_cnt++;
        if (err_timeout) begin
          check("timeout_latency", 64'(tmo_cnt), 64'(TO));
          tmo_arm = 0;
        end else if (tmo_cnt > 40) begin
          check("timeout_never_fired", 64'(err_timeout), 64'd1);
          tmo_arm = 0;
        end
      end
      prev_vin = sa_valid_in;
      prev_err = err_timeout;
    end
  end

  initial begin : main
    exp_t e;
    int w;
    rst_n = 0;
    drive(0, 1'b0, '0, '0);
    drive(1, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    check_reset("por");
    rst_n = 1;
    @(negedge clk);
    check("sa_rst_release", 64'(sa_rst_n), 64'd1);

    // Single job, requester 0
    expect_rows(0, 19, 22, 43, 50);
    do_job(0, v2(1, 3), v2(2, 4), v2(5, 6), v2(7, 8), 0);
    wait_idle();

    // Fresh pointer, two simultaneous pairs
    @(negedge clk) rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    expect_rows(0, 1, 2, 3, 4);
    expect_rows(1, 2, 2, 2, 2);
    fork
      do_job(0, v2(1, 0), v2(0, 1), v2(1, 2), v2(3, 4), 0);
      do_job(1, v2(2, 0), v2(0, 2), v2(1, 1), v2(1, 1), 0);
    join
    wait_idle();
    expect_rows(0, 4, 6, 4, 6);
    expect_rows(1, 7, 8, 5, 6);
    fork
      do_job(0, v2(1, 1), v2(1, 1), v2(1, 2), v2(3, 4), 0);
      do_job(1, v2(0, 1), v2(1, 0), v2(5, 6), v2(7, 8), 0);
    join
    wait_idle();

    // Requester 1 with a 3-cycle gap between beats
    expect_rows(1, 9, 8, 7, 6);
    do_job(1, v2(1, 0), v2(0, 1), v2(9, 8), v2(7, 6), 3);
    wait_idle();

    // Array never answers: abort, then a normal job
    stub_mute = 1;
    do_job(0, v2(1, 1), v2(1, 1), v2(1, 1), v2(1, 1), 0);
    wait_idle();
    check("timeout_count", 64'(err_cnt), 64'd1);
    check("idle_after_abort", 64'(busy), 64'd0);
    stub_mute = 0;
    expect_rows(1, 1, 2, 3, 4);
    do_job(1, v2(1, 3), v2(2, 4), v2(1, 0), v2(0, 1), 0);
    wait_idle();

    // Reset in the middle of DRAIN
    e.id = 1'b0; e.idx = 1'b0; e.row = {32'd22, 32'd19};
    sb.push_back(e);
    do_job(0, v2(1, 3), v2(2, 4), v2(5, 6), v2(7, 8), 0);
    w = 0;
    @(negedge clk);
    while (!res_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("drain_row0_bound", 64'(w >= 100), 64'd0);
    #1 rst_n = 0;
    #1 check_reset("mid_reset");
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    expect_rows(0, 1, 2, 3, 4);
    do_job(0, v2(1, 0), v2(0, 1), v2(1, 2), v2(3, 4), 0);
    wait_idle();

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    check("total_timeouts", 64'(err_cnt), 64'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
